// File: rtl/arb3_pkg.sv
// Shared types and constants for the 3-client requester agent.
// Optional build macro ARB3_REQ_TIMEOUT_EN enables the per-client REQ watchdog.
package arb3_pkg;

    localparam int NCLI  = 3;
    localparam int LEN_W = 4;
    localparam int TO_W  = 6;

    localparam logic [1:0]      ERR_MULTI = 2'd3;
    localparam logic [TO_W-1:0] TO_MAX    = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        OWN  = 2'd2,
        REL  = 2'd3
    } state_e;

    // True when more than one bit of the vector is set.
    function automatic logic multi_hot(input logic [NCLI-1:0] v);
        return (v & (v - 1'b1)) != '0;
    endfunction

    // Lowest set index; same-cycle single-client errors report the lowest client.
    function automatic logic [1:0] first_set(input logic [NCLI-1:0] v);
        logic [1:0] idx;
        idx = '0;
        for (int i = NCLI - 1; i >= 0; i--) begin
            if (v[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/arb3_req_agent_if.sv
// Host/arbiter-facing bundle of the requester agent.
// With ARB3_REQ_TIMEOUT_EN defined the bundle also carries the sticky starved flags.
interface arb3_req_agent_if;
    import arb3_pkg::*;

    logic [NCLI-1:0]       job_valid;
    logic [NCLI*LEN_W-1:0] job_len;
    logic [NCLI-1:0]       job_ready;
    logic [NCLI-1:0]       gnt;
    logic [NCLI-1:0]       req;
    logic [NCLI-1:0]       own;
    logic [NCLI-1:0]       done;
    logic                  err_gnt;
    logic [1:0]            err_cli;
`ifdef ARB3_REQ_TIMEOUT_EN
    logic [NCLI-1:0]       starved;
`endif

    modport master (
        output job_valid, job_len, gnt,
        input  job_ready, req, own, done, err_gnt, err_cli
`ifdef ARB3_REQ_TIMEOUT_EN
        , input starved
`endif
    );

    modport slave (
        input  job_valid, job_len, gnt,
        output job_ready, req, own, done, err_gnt, err_cli
`ifdef ARB3_REQ_TIMEOUT_EN
        , output starved
`endif
    );

endinterface

// File: rtl/arb3_req_fsm.sv
// Single-client requester FSM: accepts a burst, requests, owns the resource for len cycles.
// ARB3_REQ_TIMEOUT_EN adds a REQ watchdog that abandons the job and flags starvation.
module arb3_req_fsm
    import arb3_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    input  logic             gnt,
    output logic             job_ready,
    output logic             req,
    output logic             own,
    output logic             done,
    output logic             proto_err
`ifdef ARB3_REQ_TIMEOUT_EN
    ,
    output logic             starved
`endif
);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             zdone_q, zdone_d;
`ifdef ARB3_REQ_TIMEOUT_EN
    logic [TO_W-1:0]  wait_q, wait_d;
    logic             starved_q, starved_d;
`endif

    always_comb begin
        // NOTE: every combinational output gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        zdone_d = 1'b0;
`ifdef ARB3_REQ_TIMEOUT_EN
        wait_d    = wait_q;
        starved_d = starved_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef ARB3_REQ_TIMEOUT_EN
                wait_d = '0;
`endif
                if (job_valid) begin
                    if (job_len == '0) begin
                        zdone_d = 1'b1;
                    end else begin
                        // cnt holds len-1 from acceptance; it is the value loaded on grant.
                        cnt_d   = job_len - 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                if (gnt) begin
                    state_d = OWN;
`ifdef ARB3_REQ_TIMEOUT_EN
                end else if (wait_q == TO_MAX - 1'b1) begin
                    state_d   = REL;
                    starved_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
`endif
                end
            end
            OWN: begin
                // A dropped grant ends the burst early; the top records the error.
                if (!gnt || cnt_q == '0) begin
                    state_d = REL;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            REL: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            zdone_q <= 1'b0;
`ifdef ARB3_REQ_TIMEOUT_EN
            wait_q    <= '0;
            starved_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            zdone_q <= zdone_d;
`ifdef ARB3_REQ_TIMEOUT_EN
            wait_q    <= wait_d;
            starved_q <= starved_d;
`endif
        end
    end

    assign job_ready = (state_q == IDLE);
    assign req       = (state_q == REQ) || (state_q == OWN);
    assign own       = (state_q == OWN);
    assign done      = (state_q == REL) || zdone_q;
    // Unsolicited grant while not requesting, or grant lost while owning.
    assign proto_err = (gnt && (state_q == IDLE || state_q == REL)) ||
                       (!gnt && state_q == OWN);
`ifdef ARB3_REQ_TIMEOUT_EN
    assign starved   = starved_q;
`endif

endmodule

// File: rtl/arb3_req_agent.sv
// Three requester FSMs plus a sticky grant-protocol checker.
// ARB3_REQ_TIMEOUT_EN enables per-client REQ watchdogs and the starved outputs.
module arb3_req_agent
    import arb3_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    arb3_req_agent_if.slave   bus
);

    logic [NCLI-1:0] job_ready_v, req_v, own_v, done_v, cli_err;
`ifdef ARB3_REQ_TIMEOUT_EN
    logic [NCLI-1:0] starved_v;
`endif
    logic            multi;
    logic            err_gnt_q, err_gnt_d;
    logic [1:0]      err_cli_q, err_cli_d;

    for (genvar i = 0; i < NCLI; i++) begin : g_cli
        arb3_req_fsm u_fsm (
            .clk       (clk),
            .rst_n     (rst_n),
            .job_valid (bus.job_valid[i]),
            .job_len   (bus.job_len[i*LEN_W +: LEN_W]),
            .gnt       (bus.gnt[i]),
            .job_ready (job_ready_v[i]),
            .req       (req_v[i]),
            .own       (own_v[i]),
            .done      (done_v[i]),
            .proto_err (cli_err[i])
`ifdef ARB3_REQ_TIMEOUT_EN
            ,
            .starved   (starved_v[i])
`endif
        );
    end

    // First error wins; a multi-grant outranks single-client errors in the same cycle.
    always_comb begin
        multi     = multi_hot(bus.gnt);
        err_gnt_d = err_gnt_q;
        err_cli_d = err_cli_q;
        if (!err_gnt_q && (multi || (cli_err != '0))) begin
            err_gnt_d = 1'b1;
            err_cli_d = multi ? ERR_MULTI : first_set(cli_err);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_gnt_q <= 1'b0;
            err_cli_q <= 2'd0;
        end else begin
            err_gnt_q <= err_gnt_d;
            err_cli_q <= err_cli_d;
        end
    end

    assign bus.job_ready = job_ready_v;
    assign bus.req       = req_v;
    assign bus.own       = own_v;
    assign bus.done      = done_v;
    assign bus.err_gnt   = err_gnt_q;
    assign bus.err_cli   = err_cli_q;
`ifdef ARB3_REQ_TIMEOUT_EN
    assign bus.starved   = starved_v;
`endif

endmodule

// File: tb/tb_arb3_req_agent.sv
// Bench for arb3_req_agent: directed vector table, hand sequences, and randomized
// traffic against a timestamp-based reference model.
module tb_arb3_req_agent;
    import arb3_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    arb3_req_agent_if bus ();

    arb3_req_agent dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // {req, own, done, job_ready, err_gnt, err_cli}
    function automatic logic [14:0] ev(input logic [2:0] r, input logic [2:0] o,
                                       input logic [2:0] d, input logic [2:0] rdy,
                                       input logic e, input logic [1:0] c);
        return {r, o, d, rdy, e, c};
    endfunction

    function automatic logic [14:0] dut_vec();
        return {bus.req, bus.own, bus.done, bus.job_ready, bus.err_gnt, bus.err_cli};
    endfunction

    // Reference model: each client's job is tracked as absolute cycle timestamps.
    int         cyc;
    int         acc[3], len_m[3], own_start[3], own_end[3], done_c[3], zdone[3];
    logic       m_err;
    logic [1:0] m_cli;
    logic [2:0] e_req, e_own, e_done, e_ready;
    int         holder, rr;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            acc[i] = -1; len_m[i] = 0; own_start[i] = -1;
            own_end[i] = -1; done_c[i] = -1; zdone[i] = -1;
        end
        m_err = 1'b0; m_cli = 2'd0; holder = -1; rr = 0;
    endfunction

    function automatic void model_expect();
        for (int i = 0; i < 3; i++) begin
            e_req[i] = 1'b0; e_own[i] = 1'b0; e_done[i] = 1'b0; e_ready[i] = 1'b0;
            if (acc[i] < 0) begin
                e_ready[i] = 1'b1;
                e_done[i]  = (zdone[i] == cyc);
            end else if (own_start[i] < 0) begin
                e_req[i] = 1'b1;
            end else if (cyc <= own_end[i]) begin
                e_req[i] = 1'b1;
                e_own[i] = 1'b1;
            end else begin
                e_done[i] = (done_c[i] == cyc);
            end
        end
    endfunction

    function automatic logic [14:0] exp_vec();
        return {e_req, e_own, e_done, e_ready, m_err, m_cli};
    endfunction

    function automatic void model_update(input logic [2:0] jv, input logic [11:0] jl,
                                         input logic [2:0] g);
        logic [2:0] bad;
        bad = (g & ~e_req) | (e_own & ~g);
        if (!m_err && ($countones(g) > 1 || bad != 3'b000)) begin
            m_err = 1'b1;
            if ($countones(g) > 1)  m_cli = 2'd3;
            else if (bad[0])        m_cli = 2'd0;
            else if (bad[1])        m_cli = 2'd1;
            else                    m_cli = 2'd2;
        end
        for (int i = 0; i < 3; i++) begin
            int l;
            l = int'(jl[i*4 +: 4]);
            if (acc[i] < 0) begin
                if (jv[i]) begin
                    if (l == 0) zdone[i] = cyc + 1;
                    else begin acc[i] = cyc; len_m[i] = l; own_start[i] = -1; end
                end
            end else if (own_start[i] < 0) begin
                if (g[i]) begin
                    own_start[i] = cyc + 1;
                    own_end[i]   = cyc + len_m[i];
                    done_c[i]    = cyc + len_m[i] + 1;
                end
            end else if (cyc <= own_end[i]) begin
                if (!g[i]) begin own_end[i] = cyc; done_c[i] = cyc + 1; end
            end else if (cyc == done_c[i]) begin
                acc[i] = -1;
            end
        end
        cyc++;
    endfunction

    task automatic drive(input logic [2:0] jv, input logic [11:0] jl, input logic [2:0] g);
        bus.job_valid = jv;
        bus.job_len   = jl;
        bus.gnt       = g;
    endtask

    task automatic tick(input logic [2:0] jv, input logic [11:0] jl, input logic [2:0] g);
        @(negedge clk);
        model_expect();
        check("model", 32'(dut_vec()), 32'(exp_vec()));
        drive(jv, jl, g);
        model_update(jv, jl, g);
    endtask

    // Well-behaved arbiter stub: holds a grant while the holder requests, round-robin otherwise.
    task automatic run_stub(input int n, input bit rnd);
        for (int k = 0; k < n; k++) begin
            logic [2:0]  jv, g;
            logic [11:0] jl;
            model_expect();
            if (holder >= 0 && !e_req[holder]) holder = -1;
            if (holder < 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
                for (int s = 0; s < 3; s++) begin
                    int j;
                    j = (rr + s) % 3;
                    if (holder < 0 && e_req[j]) begin holder = j; rr = (j + 1) % 3; end
                end
            end
            g = (holder >= 0) ? (3'b001 << holder) : 3'b000;
            jv = 3'b000;
            jl = 12'h000;
            if (rnd) begin
                for (int i = 0; i < 3; i++) jv[i] = ($urandom_range(0, 3) == 0);
                jl = 12'($urandom());
            end
            tick(jv, jl, g);
        end
    endtask

    task automatic do_reset();
        drive(3'b000, 12'h000, 3'b000);
        #2 rst_n = 1'b0;
        #1 check("rst_async", 32'(dut_vec()), 32'(ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 2'd0)));
        model_reset();
        @(posedge clk);
        #1 check("rst_hold", 32'(dut_vec()), 32'(ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 2'd0)));
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  jv;
        logic [11:0] jl;
        logic [2:0]  g;
        logic [14:0] exp;
    } vec_t;

    vec_t vecs[15];

    initial begin
        // len=3 on client 0, unsolicited grant to idle client 2, len=1 and len=0 jobs.
        vecs[0]  = '{3'b001, 12'h003, 3'b000, ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 2'd0)};
        vecs[1]  = '{3'b000, 12'h000, 3'b001, ev(3'b001, 3'b000, 3'b000, 3'b110, 1'b0, 2'd0)};
        vecs[2]  = '{3'b000, 12'h000, 3'b001, ev(3'b001, 3'b001, 3'b000, 3'b110, 1'b0, 2'd0)};
        vecs[3]  = '{3'b000, 12'h000, 3'b001, ev(3'b001, 3'b001, 3'b000, 3'b110, 1'b0, 2'd0)};
        vecs[4]  = '{3'b000, 12'h000, 3'b001, ev(3'b001, 3'b001, 3'b000, 3'b110, 1'b0, 2'd0)};
        vecs[5]  = '{3'b000, 12'h000, 3'b000, ev(3'b000, 3'b000, 3'b001, 3'b110, 1'b0, 2'd0)};
        vecs[6]  = '{3'b000, 12'h000, 3'b100, ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 2'd0)};
        vecs[7]  = '{3'b000, 12'h000, 3'b000, ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 2'd2)};
        vecs[8]  = '{3'b100, 12'h100, 3'b000, ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 2'd2)};
        vecs[9]  = '{3'b000, 12'h000, 3'b100, ev(3'b100, 3'b000, 3'b000, 3'b011, 1'b1, 2'd2)};
        vecs[10] = '{3'b000, 12'h000, 3'b100, ev(3'b100, 3'b100, 3'b000, 3'b011, 1'b1, 2'd2)};
        vecs[11] = '{3'b000, 12'h000, 3'b000, ev(3'b000, 3'b000, 3'b100, 3'b011, 1'b1, 2'd2)};
        vecs[12] = '{3'b010, 12'h000, 3'b000, ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 2'd2)};
        vecs[13] = '{3'b000, 12'h000, 3'b000, ev(3'b000, 3'b000, 3'b010, 3'b111, 1'b1, 2'd2)};
        vecs[14] = '{3'b000, 12'h000, 3'b000, ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b1, 2'd2)};

        rst_n = 1'b0;
        drive(3'b000, 12'h000, 3'b000);
        cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset", 32'(dut_vec()), 32'(ev(3'b000, 3'b000, 3'b000, 3'b111, 1'b0, 2'd0)));
        rst_n = 1'b1;

        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            check($sformatf("vec%0d", k), 32'(dut_vec()), 32'(vecs[k].exp));
            model_expect();
            drive(vecs[k].jv, vecs[k].jl, vecs[k].g);
            model_update(vecs[k].jv, vecs[k].jl, vecs[k].g);
        end

        // All three clients offer len=2 at once; serial round-robin grants.
        @(negedge clk); do_reset();
        tick(3'b111, 12'h222, 3'b000);
        run_stub(16, 1'b0);
        check("rr_no_err", 32'(bus.err_gnt), 32'd0);

        // Multi-grant while clients 0 and 1 request; sticky across later traffic.
        @(negedge clk); do_reset();
        tick(3'b011, 12'h022, 3'b000);
        tick(3'b000, 12'h000, 3'b011);
        tick(3'b000, 12'h000, 3'b011);
        tick(3'b000, 12'h000, 3'b011);
        tick(3'b000, 12'h000, 3'b000);
        tick(3'b100, 12'h200, 3'b000);
        tick(3'b000, 12'h000, 3'b100);
        tick(3'b000, 12'h000, 3'b100);
        tick(3'b000, 12'h000, 3'b100);
        tick(3'b000, 12'h000, 3'b000);
        tick(3'b000, 12'h000, 3'b000);
        check("multi_sticky", 32'({bus.err_gnt, bus.err_cli}), 32'(3'b111));

        // Grant withdrawn during the second own cycle of a len=4 burst.
        @(negedge clk); do_reset();
        tick(3'b001, 12'h004, 3'b000);
        tick(3'b000, 12'h000, 3'b001);
        tick(3'b000, 12'h000, 3'b001);
        tick(3'b000, 12'h000, 3'b000);
        repeat (3) tick(3'b000, 12'h000, 3'b000);
        check("loss_err", 32'({bus.err_gnt, bus.err_cli}), 32'(3'b100));

        // Asynchronous reset during the third own cycle of a len=7 burst on client 1.
        @(negedge clk); do_reset();
        tick(3'b010, 12'h070, 3'b000);
        tick(3'b000, 12'h000, 3'b010);
        tick(3'b000, 12'h000, 3'b010);
        tick(3'b000, 12'h000, 3'b010);
        tick(3'b000, 12'h000, 3'b010);
        check("mid_own", 32'(bus.own), 32'(3'b010));
        do_reset();
        repeat (4) tick(3'b000, 12'h000, 3'b000);

        // Randomized jobs and stalls with a protocol-clean arbiter stub.
        @(negedge clk); do_reset();
        run_stub(1500, 1'b1);
        check("rand_no_err", 32'(bus.err_gnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
